// File: rtl/frame_packet_aligner.sv
// frame_packet_aligner
//   Re-frames a pixel stream so that every output packet holds exactly
//   WIDTH*HEIGHT pixels. There is one startofpacket on pixel 0 and one
//   endofpacket on the last pixel. Short frames are padded with FILL and
//   long frames are truncated. The block also counts completed frames and
//   pulses an error flag for each frame it had to repair.
//
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake (ready latency 0)
//   in_sop/in_eop        : upstream packet delimiters
//   in_data              : upstream pixel
//   out_valid/out_ready  : downstream handshake, single output register
//   out_sop/out_eop      : output packet delimiters
//   out_data             : output pixel
//   frame_count          : completed output frames, wraps at 16 bits
//   short_err/long_err   : one-cycle pulses: frame padded / frame truncated
module frame_packet_aligner #(
  parameter int                 WIDTH  = 320,
  parameter int                 HEIGHT = 240,
  parameter int                 DATA_W = 12,
  parameter logic [DATA_W-1:0]  FILL   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       frame_count,
  output logic              short_err,
  output logic              long_err
);

  localparam int          NPIX = WIDTH * HEIGHT;
  localparam logic [16:0] LAST = 17'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PAD, S_DISCARD} state_t;

  state_t              r_state;
  logic [1:0]          r_rst_q;
  logic [16:0]         r_pix_cnt;
  logic                r_out_valid;
  logic                r_out_sop;
  logic                r_out_eop;
  logic [DATA_W-1:0]   r_out_data;
  logic [15:0]         r_frame_count;
  logic                r_short_err;
  logic                r_long_err;

  logic                w_rst_n;
  logic                w_can_load;
  logic                w_last;
  logic                w_in_xfer;
  logic                w_load;
  logic [DATA_W-1:0]   w_ld_data;

  // Reset asserts immediately but is released on a clock edge, so every
  // state flop leaves reset in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_q <= 2'b00;
    else          r_rst_q <= {r_rst_q[0], 1'b1};
  end
  assign w_rst_n = r_rst_q[1];

  assign w_can_load = !r_out_valid || out_ready;
  assign w_last     = (r_pix_cnt == LAST);
  assign w_in_xfer  = in_valid && in_ready;

  always_comb begin
    in_ready  = 1'b0;
    w_load    = 1'b0;
    w_ld_data = in_data;
    if (w_rst_n) begin
      case (r_state)
        S_IDLE: begin
          in_ready = w_can_load;
          w_load   = w_in_xfer && in_sop;
        end
        S_ACTIVE: begin
          // A mid-frame SOP is held off until the current frame is padded.
          in_ready = w_can_load && !in_sop;
          w_load   = w_in_xfer;
        end
        S_PAD: begin
          w_load    = w_can_load;
          w_ld_data = FILL;
        end
        S_DISCARD: begin
          // An SOP is left waiting so IDLE can start the next frame with it.
          in_ready = !in_sop;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_pix_cnt     <= '0;
      r_out_valid   <= 1'b0;
      r_out_sop     <= 1'b0;
      r_out_eop     <= 1'b0;
      r_out_data    <= '0;
      r_frame_count <= '0;
      r_short_err   <= 1'b0;
      r_long_err    <= 1'b0;
    end else begin
      r_short_err <= 1'b0;
      r_long_err  <= 1'b0;

      if (w_can_load) r_out_valid <= w_load;
      if (w_load) begin
        r_out_data <= w_ld_data;
        r_out_sop  <= (r_pix_cnt == 17'd0);
        r_out_eop  <= w_last;
        if (w_last) begin
          r_pix_cnt     <= '0;
          r_frame_count <= r_frame_count + 16'd1;
        end else begin
          r_pix_cnt <= r_pix_cnt + 17'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else if (in_eop) begin
              r_state     <= S_PAD;
              r_short_err <= 1'b1;
            end else begin
              r_state <= S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (in_valid && in_sop) begin
            r_state     <= S_PAD;
            r_short_err <= 1'b1;
          end else if (w_load) begin
            if (w_last) begin
              if (in_eop) begin
                r_state <= S_IDLE;
              end else begin
                r_state    <= S_DISCARD;
                r_long_err <= 1'b1;
              end
            end else if (in_eop) begin
              r_state     <= S_PAD;
              r_short_err <= 1'b1;
            end
          end
        end
        S_PAD: begin
          if (w_load && w_last) r_state <= S_IDLE;
        end
        S_DISCARD: begin
          if (in_valid && (in_sop || in_eop)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_data    = r_out_data;
  assign frame_count = r_frame_count;
  assign short_err   = r_short_err;
  assign long_err    = r_long_err;

endmodule

// File: tb/tb_frame_packet_aligner.sv
module tb_frame_packet_aligner;
  localparam int          W     = 4;
  localparam int          H     = 3;
  localparam int          DW    = 12;
  localparam logic [11:0] FILLV = 12'hABC;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_sop, in_eop;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic [15:0]   frame_count;
  logic          short_err, long_err;

  always #5 clk = ~clk;

  frame_packet_aligner #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .FILL(FILLV)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .frame_count(frame_count), .short_err(short_err), .long_err(long_err)
  );

  typedef struct {
    logic        iv, isop, ieop;
    logic [11:0] idata;
    logic        ordy;
    logic        erdy;
    logic        ev, esop, eeop;
    logic [11:0] edata;
    logic        eshort, elong;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int iv, input int isop, input int ieop, input int idata, input int ordy,
                      input int erdy, input int ev, input int esop, input int eeop, input int edata,
                      input int es, input int el);
    vec_t v;
    v.iv = 1'(iv); v.isop = 1'(isop); v.ieop = 1'(ieop); v.idata = 12'(idata); v.ordy = 1'(ordy);
    v.erdy = 1'(erdy); v.ev = 1'(ev); v.esop = 1'(esop); v.eeop = 1'(eeop); v.edata = 12'(edata);
    v.eshort = 1'(es); v.elong = 1'(el);
    vq.push_back(v);
  endtask

  task automatic push_idle();
    push(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_nominal(input int base);
    for (int i = 0; i < 12; i++)
      push(1, i == 0, i == 11, base + i, 1, 1, 1, i == 0, i == 11, base + i, 0, 0);
    push_idle();
  endtask

  // Called just after a rising edge; drives each record, checks in_ready
  // before the edge and the registered outputs after it.
  task automatic run_vectors(input string tag);
    for (int k = 0; k < vq.size(); k++) begin
      in_valid = vq[k].iv; in_sop = vq[k].isop; in_eop = vq[k].ieop;
      in_data = vq[k].idata; out_ready = vq[k].ordy;
      #1;
      chk($sformatf("%s[%0d].in_ready", tag, k), int'(in_ready), int'(vq[k].erdy));
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].out_valid", tag, k), int'(out_valid), int'(vq[k].ev));
      chk($sformatf("%s[%0d].short_err", tag, k), int'(short_err), int'(vq[k].eshort));
      chk($sformatf("%s[%0d].long_err", tag, k), int'(long_err), int'(vq[k].elong));
      if (vq[k].ev) begin
        chk($sformatf("%s[%0d].out_data", tag, k), int'(out_data), int'(vq[k].edata));
        chk($sformatf("%s[%0d].out_sop", tag, k), int'(out_sop), int'(vq[k].esop));
        chk($sformatf("%s[%0d].out_eop", tag, k), int'(out_eop), int'(vq[k].eeop));
      end
    end
    vq.delete();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; out_ready = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic        pat [4];
    logic [11:0] gdata[$];
    logic        gsop[$], geop[$];
    logic [13:0] held;
    logic        stall_prev, acc;
    int          j, cyc, ng;

    reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.frame_count", int'(frame_count), 0);
    chk("reset.in_ready", int'(in_ready), 0);
    chk("reset.short_err", int'(short_err), 0);
    chk("reset.long_err", int'(long_err), 0);
    release_reset();

    // Nominal frame.
    push_nominal(12'h100);
    // Short frame: EOP on beat 4, seven FILL pixels follow.
    for (int i = 0; i < 5; i++)
      push(1, i == 0, i == 4, 12'h200 + i, 1, 1, 1, i == 0, 0, 12'h200 + i, i == 4, 0);
    for (int k = 5; k < 12; k++)
      push(0, 0, 0, 0, 1, 0, 1, 0, k == 11, FILLV, 0, 0);
    push_idle();
    // Long frame: 15 beats, only the first 12 leave.
    for (int i = 0; i < 15; i++) begin
      if (i < 12) push(1, i == 0, 0, 12'h300 + i, 1, 1, 1, i == 0, i == 11, 12'h300 + i, 0, i == 11);
      else        push(1, 0, i == 14, 12'h300 + i, 1, 1, 0, 0, 0, 0, 0, 0);
    end
    push_idle();
    run_vectors("basic");
    chk("basic.frame_count", int'(frame_count), 3);

    // Backpressure: out_ready cycles 1,0,0,1.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    j = 0; cyc = 0; ng = 0; stall_prev = 1'b0; held = '0;
    while (ng < 12 && cyc < 100) begin
      in_valid = (j < 12); in_sop = (j == 0); in_eop = (j == 11);
      in_data = 12'(12'h800 + j); out_ready = pat[cyc % 4];
      @(negedge clk);
      if (stall_prev)
        chk("bp.hold", int'({out_valid, out_sop, out_eop, out_data}), int'({1'b1, held}));
      if (out_valid && !out_ready)
        chk("bp.in_ready_stalled", int'(in_ready), 0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        gdata.push_back(out_data); gsop.push_back(out_sop); geop.push_back(out_eop);
        ng++;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_sop, out_eop, out_data};
      @(posedge clk); #1;
      if (acc) j++;
      cyc++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.beats_out", ng, 12);
    chk("bp.beats_in", j, 12);
    for (int k = 0; k < gdata.size(); k++) begin
      chk($sformatf("bp[%0d].data", k), int'(gdata[k]), 12'h800 + k);
      chk($sformatf("bp[%0d].sop", k), int'(gsop[k]), int'(k == 0));
      chk($sformatf("bp[%0d].eop", k), int'(geop[k]), int'(k == 11));
    end
    chk("bp.frame_count", int'(frame_count), 4);

    // Leading garbage, then an SOP at beat 6 of the first frame.
    for (int g = 0; g < 3; g++)
      push(1, 0, 0, 12'hF00 + g, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      push(1, i == 0, 0, 12'h400 + i, 1, 1, 1, i == 0, 0, 12'h400 + i, 0, 0);
    push(1, 1, 0, 12'h500, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 6; k < 12; k++)
      push(1, 1, 0, 12'h500, 1, 0, 1, 0, k == 11, FILLV, 0, 0);
    push_nominal(12'h500);
    run_vectors("midsop");
    chk("midsop.frame_count", int'(frame_count), 6);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = 1'b0; in_data = 12'(12'h600 + i); out_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("arst.pre_out_valid", int'(out_valid), 1);
    in_valid = 1'b0; in_sop = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.out_sop", int'(out_sop), 0);
    chk("arst.out_eop", int'(out_eop), 0);
    chk("arst.frame_count", int'(frame_count), 0);
    chk("arst.in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    release_reset();
    push_nominal(12'h700);
    run_vectors("after_rst");
    chk("after_rst.frame_count", int'(frame_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_packet_aligner.md
Name: frame_packet_aligner

Overview:
- Sits directly downstream of the blurring filter, between it and the video output / frame-buffer writer.
- Takes the filter's pixel stream and re-frames it so that every output packet is exactly WIDTH*HEIGHT pixels, with one startofpacket on the first pixel and one endofpacket on the last.
- Short frames are padded with FILL pixels. Long frames are truncated.
- Counts completed frames and reports framing errors.

Parameters:
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- DATA_W, 12, pixel width (RGB444)
- FILL, 12'h000, pixel value used for padding

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  this block can accept a beat
- in_sop  in  1  upstream startofpacket
- in_eop  in  1  upstream endofpacket
- in_data  in  DATA_W  upstream pixel
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream can accept
- out_sop  out  1  output startofpacket
- out_eop  out  1  output endofpacket
- out_data  out  DATA_W  output pixel
- frame_count  out  16  completed output frames, wraps at 65535->0
- short_err  out  1  one-cycle pulse: frame padded
- long_err  out  1  one-cycle pulse: frame truncated

Behaviour:
- Reset is async active-low and clocked out synchronously. All outputs, counters and state clear to 0. State goes to IDLE. in_ready reads 0 while reset_n is low.
- Handshake (ready latency 0):
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
  - Output uses a single register stage. It can load when !out_valid || out_ready.
  - out_valid, out_data, out_sop and out_eop hold stable while out_valid && !out_ready.
- Latency: an accepted beat appears on the output the next cycle. Full throughput of one pixel/cycle when out_ready stays high.
- Pixel counter: pix_cnt runs 0..WIDTH*HEIGHT-1 (17 bits). It counts output-register loads within the frame.
  - out_sop = (pix_cnt==0).
  - out_eop = (pix_cnt==WIDTH*HEIGHT-1).
  - On loading the EOP beat, pix_cnt returns to 0 and frame_count increments.
- IDLE:
  - in_ready = output can load.
  - Beats without in_sop are accepted and dropped.
  - A beat with in_sop is forwarded as pixel 0 and the state goes to ACTIVE. If that beat also has in_eop and WIDTH*HEIGHT>1, the state goes to PAD instead.
- ACTIVE:
  - Beats are forwarded.
  - in_eop arriving before the last pixel: forward the beat, pulse short_err, go to PAD.
  - Last pixel loaded without in_eop: pulse long_err, go to DISCARD.
  - Last pixel with in_eop: go to IDLE, no error.
  - in_sop arriving mid-frame (pix_cnt>0): do not accept that beat (in_ready=0), pulse short_err, go to PAD. After padding, the beat is taken in IDLE as a new SOP.
- PAD:
  - in_ready=0.
  - Load FILL each cycle the output can load, until the EOP pixel is loaded, then go to IDLE.
- DISCARD:
  - in_ready=1. Accepted beats are dropped.
  - A beat with in_eop is dropped and the state goes to IDLE.
  - A beat with in_sop is not accepted (in_ready=0 on that cycle) and the state goes to IDLE, where it starts the next frame.
- Error pulses are asserted for exactly one cycle, on the cycle the transition is taken.
- Reset mid-frame: the partial frame is abandoned. No EOP is emitted for it, and frame_count is not incremented.

Test Plan:
(bench uses WIDTH=4, HEIGHT=3, FILL=12'hABC)
- Nominal: 12-beat frame, in_sop on beat 0, in_eop on beat 11, out_ready=1 -> 12 outputs one cycle delayed, data identical; out_sop only on beat 0, out_eop only on beat 11; frame_count=1; no error pulses.
- Short frame: in_eop on beat 4 -> outputs beats 0..4 as input, then 7 pixels of 12'hABC with out_eop on the 12th; short_err pulses once; in_ready=0 during padding.
- Long frame: 15 beats, in_eop on beat 14 -> only the first 12 are output, with out_eop on beat 11; long_err pulses once; beats 12..14 are dropped; frame_count=1.
- Backpressure: out_ready toggles 1,0,0,1 during the nominal frame -> no beat lost or duplicated; outputs stable while stalled; in_ready=0 whenever out_valid && !out_ready.
- Leading garbage and mid-frame SOP: 3 beats before the first in_sop are dropped. A second in_sop at beat 6 -> first frame padded to 12 with 12'hABC, then the second frame starts with that beat as its pixel 0; short_err pulses once.
- Async reset: assert reset_n=0 mid-frame between clock edges -> out_valid, out_sop, out_eop and frame_count read 0 immediately; after release a clean 12-beat frame produces frame_count=1.
